// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory/writeback stage.
// Access-type encodings, store lane masks and exception codes.
package mem_wb_stage_pkg;

    localparam int DM_AW_DEFAULT = 12;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_W,
        ACC_H,
        ACC_HU,
        ACC_B,
        ACC_BU
    } load_t;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_W,
        ST_H,
        ST_B
    } store_t;

    // Lane masks for the lowest-addressed lane group; shifted by address bits.
    localparam logic [3:0] LANE_SW = 4'b1111;
    localparam logic [3:0] LANE_SH = 4'b0011;
    localparam logic [3:0] LANE_SB = 4'b0001;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    function automatic load_t decode_load(
        input logic lw,
        input logic lh,
        input logic lhu,
        input logic lb,
        input logic lbu
    );
        load_t t;
        t = ACC_NONE;
        if (lw)       t = ACC_W;
        else if (lh)  t = ACC_H;
        else if (lhu) t = ACC_HU;
        else if (lb)  t = ACC_B;
        else if (lbu) t = ACC_BU;
        return t;
    endfunction

endpackage

// File: rtl/mem_wb_stage_dm_load_ext.sv
// Combinational load extract/extend: picks the half or byte lane out of a
// memory word and sign- or zero-extends it to 32 bits.
module dm_load_ext
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  load_t       load_type,
    output logic [31:0] data
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        byte_v = word[7:0];
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase

        data = '0;
        case (load_type)
            ACC_W:   data = word;
            ACC_H:   data = {{16{half_v[15]}}, half_v};
            ACC_HU:  data = {16'h0000, half_v};
            ACC_B:   data = {{24{byte_v[7]}}, byte_v};
            ACC_BU:  data = {24'h000000, byte_v};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory stage with data memory and the M/W pipeline register.
// Optional alignment exceptions are enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int          DM_AW   = DM_AW_DEFAULT,
    parameter logic [31:0] DM_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] ALUresultM,
    input  logic [31:0] MemWriteDataM,
    input  logic [31:0] PCplus4M,
    input  logic        jalM,
    input  logic        jalrM,
    input  logic        bgezalrM,
    input  logic        swM,
    input  logic        shM,
    input  logic        sbM,
    input  logic        lwM,
    input  logic        lhM,
    input  logic        lhuM,
    input  logic        lbM,
    input  logic        lbuM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ALUresultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCplus4W,
    output logic        jalW,
    output logic        jalrW,
    output logic        bgezalrW,
    output logic        ExcAdELW,
    output logic        ExcAdESW
);

    logic [31:0]      mem [2**DM_AW];
    logic [DM_AW+1:0] dm_off;
    logic [DM_AW-1:0] idx;
    logic [1:0]       lo;
    load_t            ld_type;
    store_t           st_type;
    logic [3:0]       lane_mask;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;

    // Only the low DM_AW+2 offset bits matter: higher address bits wrap.
    assign dm_off = ALUresultM[DM_AW+1:0] - DM_BASE[DM_AW+1:0];
    assign idx    = dm_off[DM_AW+1:2];
    assign lo     = dm_off[1:0];

    always_comb begin
        ld_type = decode_load(lwM, lhM, lhuM, lbM, lbuM);
        st_type = ST_NONE;
        if (MemWriteM && (({1'b0, swM} + {1'b0, shM} + {1'b0, sbM}) == 2'd1)) begin
            if (swM)      st_type = ST_W;
            else if (shM) st_type = ST_H;
            else          st_type = ST_B;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_ld;
    logic mis_st;

    always_comb begin
        mis_ld = ((ld_type == ACC_W) && (lo != 2'd0))
              || (((ld_type == ACC_H) || (ld_type == ACC_HU)) && lo[0]);
        mis_st = ((st_type == ST_W) && (lo != 2'd0))
              || ((st_type == ST_H) && lo[0]);
    end
`endif

    always_comb begin
        lane_mask = '0;
        wr_data   = '0;
        case (st_type)
            ST_W: begin
                lane_mask = LANE_SW;
                wr_data   = MemWriteDataM;
            end
            ST_H: begin
                lane_mask = lo[1] ? (LANE_SH << 2) : LANE_SH;
                wr_data   = {2{MemWriteDataM[15:0]}};
            end
            ST_B: begin
                lane_mask = LANE_SB << lo;
                wr_data   = {4{MemWriteDataM[7:0]}};
            end
            default: begin
                lane_mask = '0;
                wr_data   = '0;
            end
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        if (mis_st) lane_mask = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**DM_AW; i++) mem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[idx];

    dm_load_ext u_load_ext (
        .word      (rd_word),
        .addr_lo   (lo),
        .load_type (ld_type),
        .data      (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            MemtoRegW  <= 1'b0;
            WriteRegW  <= '0;
            ALUresultW <= '0;
            ReadDataW  <= '0;
            PCplus4W   <= '0;
            jalW       <= 1'b0;
            jalrW      <= 1'b0;
            bgezalrW   <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM;
            MemtoRegW  <= MemtoRegM;
            WriteRegW  <= WriteRegM;
            ALUresultW <= ALUresultM;
            ReadDataW  <= ld_data;
            PCplus4W   <= PCplus4M;
            jalW       <= jalM;
            jalrW      <= jalrM;
            bgezalrW   <= bgezalrM;
`ifdef MEM_ALIGN_CHECK_EN
            if (mis_ld) begin
                ReadDataW <= '0;
                RegWriteW <= 1'b0;
            end
`endif
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ExcAdELW <= 1'b0;
            ExcAdESW <= 1'b0;
        end else begin
            ExcAdELW <= mis_ld;
            ExcAdESW <= mis_st;
        end
    end
`else
    assign ExcAdELW = 1'b0;
    assign ExcAdESW = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: byte-addressed reference model,
// directed literal checks followed by randomized traffic.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUresultM, MemWriteDataM, PCplus4M;
    logic        jalM, jalrM, bgezalrM;
    logic        swM, shM, sbM, lwM, lhM, lhuM, lbM, lbuM;
    logic        RegWriteW, MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [31:0] ALUresultW, ReadDataW, PCplus4W;
    logic        jalW, jalrW, bgezalrW, ExcAdELW, ExcAdESW;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  write_reg;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc4;
        logic        jal;
        logic        jalr;
        logic        bgezalr;
        logic        adel;
        logic        ades;
    } exp_t;

    localparam int MEM_BYTES = 16384;

    logic [7:0] ref_bytes [MEM_BYTES];
    exp_t       exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .WriteRegM(WriteRegM), .ALUresultM(ALUresultM), .MemWriteDataM(MemWriteDataM),
        .PCplus4M(PCplus4M), .jalM(jalM), .jalrM(jalrM), .bgezalrM(bgezalrM),
        .swM(swM), .shM(shM), .sbM(sbM), .lwM(lwM), .lhM(lhM), .lhuM(lhuM),
        .lbM(lbM), .lbuM(lbuM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
        .ALUresultW(ALUresultW), .ReadDataW(ReadDataW), .PCplus4W(PCplus4W),
        .jalW(jalW), .jalrW(jalrW), .bgezalrW(bgezalrW),
        .ExcAdELW(ExcAdELW), .ExcAdESW(ExcAdESW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed little-endian memory, one instruction per cycle.
    task automatic model_eval();
        exp_t e;
        int   a, wa, ha, nst;
        logic mis_l, mis_s, do_wr;
        assert ($countones({swM, shM, sbM, lwM, lhM, lhuM, lbM, lbuM}) <= 1)
            else $error("more than one access flag set");
        e = '0;
        if (reset) begin
            foreach (ref_bytes[i]) ref_bytes[i] = 8'h00;
            exp_q.push_back(e);
            return;
        end
        a   = int'(ALUresultM[13:0]);
        wa  = a - (a % 4);
        ha  = a - (a % 2);
        nst = int'(swM) + int'(shM) + int'(sbM);
        mis_l = (lwM && (a % 4 != 0)) || ((lhM || lhuM) && (a % 2 != 0));
        mis_s = MemWriteM && (nst == 1) && ((swM && (a % 4 != 0)) || (shM && (a % 2 != 0)));

        e.reg_write  = RegWriteM;
        e.mem_to_reg = MemtoRegM;
        e.write_reg  = WriteRegM;
        e.alu        = ALUresultM;
        e.pc4        = PCplus4M;
        e.jal        = jalM;
        e.jalr       = jalrM;
        e.bgezalr    = bgezalrM;
        if (lwM)       e.rd = {ref_bytes[wa+3], ref_bytes[wa+2], ref_bytes[wa+1], ref_bytes[wa]};
        else if (lhM)  e.rd = {{16{ref_bytes[ha+1][7]}}, ref_bytes[ha+1], ref_bytes[ha]};
        else if (lhuM) e.rd = {16'h0000, ref_bytes[ha+1], ref_bytes[ha]};
        else if (lbM)  e.rd = {{24{ref_bytes[a][7]}}, ref_bytes[a]};
        else if (lbuM) e.rd = {24'h000000, ref_bytes[a]};
        do_wr = MemWriteM && (nst == 1);
`ifdef MEM_ALIGN_CHECK_EN
        if (mis_l) begin
            e.rd        = '0;
            e.reg_write = 1'b0;
            e.adel      = 1'b1;
        end
        e.ades = mis_s;
        if (mis_s) do_wr = 1'b0;
`endif
        exp_q.push_back(e);

        if (do_wr) begin
            if (swM) begin
                for (int k = 0; k < 4; k++) ref_bytes[wa+k] = MemWriteDataM[8*k +: 8];
            end else if (shM) begin
                ref_bytes[ha]   = MemWriteDataM[7:0];
                ref_bytes[ha+1] = MemWriteDataM[15:8];
            end else begin
                ref_bytes[a] = MemWriteDataM[7:0];
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("RegWriteW",  {31'b0, RegWriteW},  {31'b0, e.reg_write});
            check("MemtoRegW",  {31'b0, MemtoRegW},  {31'b0, e.mem_to_reg});
            check("WriteRegW",  {27'b0, WriteRegW},  {27'b0, e.write_reg});
            check("ALUresultW", ALUresultW,          e.alu);
            check("ReadDataW",  ReadDataW,           e.rd);
            check("PCplus4W",   PCplus4W,            e.pc4);
            check("link_flags", {29'b0, jalW, jalrW, bgezalrW}, {29'b0, e.jal, e.jalr, e.bgezalr});
            check("exc_flags",  {30'b0, ExcAdELW, ExcAdESW},    {30'b0, e.adel, e.ades});
        end
    end

    task automatic clear_inputs();
        reset = 1'b0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
        WriteRegM = '0; ALUresultM = '0; MemWriteDataM = '0; PCplus4M = '0;
        jalM = 1'b0; jalrM = 1'b0; bgezalrM = 1'b0;
        swM = 1'b0; shM = 1'b0; sbM = 1'b0;
        lwM = 1'b0; lhM = 1'b0; lhuM = 1'b0; lbM = 1'b0; lbuM = 1'b0;
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #2;
    endtask

    // kind: 0 sw, 1 sh, 2 sb, 3 none
    task automatic do_store(input int kind, input logic [31:0] addr, input logic [31:0] data);
        clear_inputs();
        MemWriteM = 1'b1;
        ALUresultM = addr;
        MemWriteDataM = data;
        swM = (kind == 0);
        shM = (kind == 1);
        sbM = (kind == 2);
        cycle();
    endtask

    // kind: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu
    task automatic do_load(input int kind, input logic [31:0] addr);
        clear_inputs();
        RegWriteM = 1'b1;
        MemtoRegM = 1'b1;
        WriteRegM = 5'd8;
        ALUresultM = addr;
        lwM  = (kind == 0);
        lhM  = (kind == 1);
        lhuM = (kind == 2);
        lbM  = (kind == 3);
        lbuM = (kind == 4);
        cycle();
    endtask

    initial begin
        logic [31:0] cur;
        clear_inputs();
        reset = 1'b1;
        cycle();
        check("rst_outputs", {RegWriteW, MemtoRegW, WriteRegW, jalW, jalrW, bgezalrW,
                              ExcAdELW, ExcAdESW}, 32'h0);
        check("rst_data", ALUresultW | ReadDataW | PCplus4W, 32'h0);

        do_load(0, 32'h10);
        check("lw_after_reset", ReadDataW, 32'h0);

        do_store(0, 32'h20, 32'h1234_5678);
        do_load(0, 32'h20);
        check("sw_lw", ReadDataW, 32'h1234_5678);

        do_store(0, 32'h20, 32'h1122_3344);
        do_store(2, 32'h23, 32'h0000_00AB);
        do_load(0, 32'h20);
        check("sb_word", ReadDataW, 32'hAB22_3344);
        do_load(3, 32'h23);
        check("lb", ReadDataW, 32'hFFFF_FFAB);
        do_load(4, 32'h23);
        check("lbu", ReadDataW, 32'h0000_00AB);

        do_store(1, 32'h22, 32'h0000_8001);
        do_load(0, 32'h20);
        check("sh_word", ReadDataW, 32'h8001_3344);
        do_load(1, 32'h22);
        check("lh", ReadDataW, 32'hFFFF_8001);
        do_load(2, 32'h22);
        check("lhu", ReadDataW, 32'h0000_8001);

        clear_inputs();
        PCplus4M = 32'h3004; jalM = 1'b1; WriteRegM = 5'd31; RegWriteM = 1'b1;
        ALUresultM = 32'h20;
        cycle();
        check("jal_pc4", PCplus4W, 32'h3004);
        check("jal_reg", {26'b0, jalW, WriteRegW}, {26'b0, 1'b1, 5'd31});
        do_load(0, 32'h4020);
        check("wrap_lw", ReadDataW, 32'h8001_3344);

        do_store(0, 32'h21, 32'hCAFE_BABE);
`ifdef MEM_ALIGN_CHECK_EN
        check("ades", {31'b0, ExcAdESW}, 32'h1);
        cur = 32'h8001_3344;
        do_load(0, 32'h20);
        check("mis_sw_word", ReadDataW, cur);
        do_load(1, 32'h23);
        check("adel", {30'b0, RegWriteW, ExcAdELW}, 32'h1);
`else
        cur = 32'hCAFE_BABE;
        do_load(0, 32'h20);
        check("forced_sw_word", ReadDataW, cur);
        do_load(1, 32'h23);
        check("forced_lh", ReadDataW, 32'hFFFF_CAFE);
`endif

        do_store(3, 32'h20, 32'h0);
        do_load(0, 32'h20);
        check("memwrite_noflag", ReadDataW, cur);

        do_store(0, 32'h20, 32'hFFFF_FFFF);
        clear_inputs();
        reset = 1'b1; MemWriteM = 1'b1; swM = 1'b1;
        ALUresultM = 32'h24; MemWriteDataM = 32'h5555_AAAA;
        cycle();
        do_load(0, 32'h20);
        check("rst_clears_mem", ReadDataW, 32'h0);
        do_load(0, 32'h24);
        check("rst_drops_store", ReadDataW, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            int kind, sel;
            clear_inputs();
            reset     = ($urandom_range(0, 99) < 2);
            RegWriteM = 1'($urandom);
            MemtoRegM = 1'($urandom);
            WriteRegM = 5'($urandom);
            PCplus4M  = $urandom;
            sel = $urandom_range(0, 3);
            jalM = (sel == 1); jalrM = (sel == 2); bgezalrM = (sel == 3);
            kind = $urandom_range(0, 3);
            if (kind == 0 || kind == 3) begin
                ALUresultM = $urandom;
            end else begin
                ALUresultM = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 14);
            end
            if (kind == 1) begin
                sel = $urandom_range(0, 3);
                MemWriteM = ($urandom_range(0, 9) != 0);
                MemWriteDataM = $urandom;
                swM = (sel == 0); shM = (sel == 1); sbM = (sel == 2);
            end else if (kind == 2) begin
                sel = $urandom_range(0, 4);
                lwM = (sel == 0); lhM = (sel == 1); lhuM = (sel == 2);
                lbM = (sel == 3); lbuM = (sel == 4);
            end
            cycle();
        end

        clear_inputs();
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
